// File: rtl/regfile_param.sv
`default_nettype none
// =============================================================================
// Module   : regfile_param
// Brief    : Two-read/one-write register file with optional hardwired zero
//            register, write-to-read forwarding and a sequential sweep clear.
// Revision : 1.0 - initial release
// =============================================================================
module regfile_param #(
    parameter int  WIDTH    = 64,
    parameter int  DEPTH    = 32,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] da,
    output logic [WIDTH-1:0] db,
    input  logic             clr,
    output logic             busy
);

    localparam logic [0:0]    IDLE      = 1'b0;
    localparam logic [0:0]    SWEEP     = 1'b1;
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH-1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    cnt_nxt;
    logic             sweep_en;
    logic             wr_accept;

    // An address is live if it maps to real storage and is not the zero register.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == LAST));
    endfunction

    assign wr_accept = we && !busy && !clr && addr_live(wa);

    // Storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweep_en) begin
            mem[cnt] <= '0;
        end else if (wr_accept) begin
            mem[wa] <= wd;
        end
    end

    // Sweep FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep FSM: next state; cnt parks at zero so it never runs past LAST
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Sweep FSM: outputs
    always_comb begin
        busy     = (state == SWEEP);
        sweep_en = (state == SWEEP);
    end

    always_comb begin
        da = '0;
        if (addr_live(ra)) begin
            da = ((BYPASS != 0) && wr_accept && (ra == wa)) ? wd : mem[ra];
        end
    end

    always_comb begin
        db = '0;
        if (addr_live(rb)) begin
            db = ((BYPASS != 0) && wr_accept && (rb == wa)) ? wd : mem[rb];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// =============================================================================
// Module   : tb_regfile_param
// Brief    : Directed self-checking bench for regfile_param (default and
//            small non-power-of-two configurations).
// Revision : 1.0 - initial release
// =============================================================================
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        we, clr, busy;
    logic [4:0]  wa, ra, rb;
    logic [63:0] wd, da, db;

    logic        we2, clr2, busy2;
    logic [2:0]  wa2, ra2, rb2;
    logic [7:0]  wd2, da2, db2;

    int vectors     = 0;
    int miscompares = 0;
    int nbusy;

    regfile_param dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra(ra), .rb(rb), .da(da), .db(db), .clr(clr), .busy(busy)
    );

    regfile_param #(.WIDTH(8), .DEPTH(5), .ZERO_REG(0), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we2), .wa(wa2), .wd(wd2),
        .ra(ra2), .rb(rb2), .da(da2), .db(db2), .clr(clr2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps run from 2 time units after a rising edge, well clear of both edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        we = 0; clr = 0; wa = 0; wd = 0; ra = 0; rb = 0;
        we2 = 0; clr2 = 0; wa2 = 0; wd2 = 0; ra2 = 0; rb2 = 0;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_da", da, 64'd0);
        #9 rst_n = 1'b1;
        tick();

        // All entries read zero after reset
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a);
            rb = 5'(31 - a);
            #1;
            chk("reset_da", da, 64'd0);
            chk("reset_db", db, 64'd0);
        end
        chk("reset_busy", 64'(busy), 64'd0);

        // Same-cycle forwarding, then committed value
        tick();
        we = 1; wa = 5; wd = 64'hDEADBEEF_CAFEF00D; ra = 5; rb = 6;
        #1;
        chk("bypass_da", da, 64'hDEADBEEF_CAFEF00D);
        chk("bypass_db_other", db, 64'd0);
        tick();
        we = 0;
        #1;
        chk("after_edge_da", da, 64'hDEADBEEF_CAFEF00D);

        // Zero register ignores writes and never forwards
        we = 1; wa = 31; wd = 64'h1; ra = 31;
        #1;
        chk("zero_reg_bypass", da, 64'd0);
        tick();
        we = 0;
        #1;
        chk("zero_reg_read", da, 64'd0);

        // Fill 0..30 with their index
        for (int k = 0; k < 31; k++) begin
            we = 1; wa = 5'(k); wd = 64'(k);
            tick();
        end
        we = 0; ra = 17; rb = 30;
        #1;
        chk("fill_17", da, 64'd17);
        chk("fill_30", db, 64'd30);

        // Sweep with a colliding write: clear wins
        clr = 1; we = 1; wa = 3; wd = 64'hFFFF;
        tick();
        clr = 0; we = 0;
        for (int j = 1; j <= 32; j++) begin
            ra = (j >= 2) ? 5'(j - 2) : 5'd3;
            rb = 5'(j - 1);
            #1;
            chk("sweep1_busy", 64'(busy), 64'd1);
            chk("sweep1_swept", da, (j >= 2) ? 64'd0 : 64'd3);
            chk("sweep1_unswept", db, (j - 1 <= 30) ? 64'(j - 1) : 64'd0);
            tick();
        end
        ra = 30; rb = 3;
        #1;
        chk("sweep1_done_busy", 64'(busy), 64'd0);
        chk("sweep1_done_30", da, 64'd0);
        chk("sweep1_done_3", db, 64'd0);

        // Second sweep: re-pulsed clr and writes during sweep are ignored
        we = 1; wa = 10; wd = 64'h1010;
        tick();
        wa = 25; wd = 64'h2525;
        tick();
        we = 0; clr = 1;
        tick();
        clr = 0;
        for (int j = 1; j <= 32; j++) begin
            clr = (j == 10);
            we = 1; wa = 25; wd = 64'hBAD; ra = 25; rb = 10;
            #1;
            chk("sweep2_busy", 64'(busy), 64'd1);
            chk("sweep2_r25", da, (j <= 26) ? 64'h2525 : 64'd0);
            chk("sweep2_r10", db, (j <= 11) ? 64'h1010 : 64'd0);
            tick();
        end
        clr = 0; we = 0;
        #1;
        chk("sweep2_end_busy", 64'(busy), 64'd0);
        chk("sweep2_end_r25", da, 64'd0);
        tick();
        chk("sweep2_stays_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a sweep
        we = 1; wa = 30; wd = 64'h3030;
        tick();
        wa = 20; wd = 64'h2020;
        tick();
        we = 0; clr = 1;
        tick();
        clr = 0;
        for (int j = 1; j < 7; j++) tick();
        ra = 30; rb = 20;
        #1;
        chk("pre_abort_busy", 64'(busy), 64'd1);
        chk("pre_abort_r30", da, 64'h3030);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_da", da, 64'd0);
        chk("abort_db", db, 64'd0);
        rst_n = 1'b1;
        #1;
        we = 1; wa = 2; wd = 64'h55;
        tick();
        we = 0; ra = 2; rb = 30;
        #1;
        chk("post_abort_write", da, 64'h55);
        chk("post_abort_r30", db, 64'd0);
        chk("post_abort_busy", 64'(busy), 64'd0);

        // Small non-power-of-two instance
        we2 = 1; wa2 = 4; wd2 = 8'h44;
        tick();
        wa2 = 1; wd2 = 8'h11;
        tick();
        we2 = 0; ra2 = 4; rb2 = 1;
        #1;
        chk("b_r4", 64'(da2), 64'h44);
        chk("b_r1", 64'(db2), 64'h11);
        ra2 = 6;
        #1;
        chk("b_oob_read", 64'(da2), 64'd0);
        we2 = 1; wa2 = 6; wd2 = 8'hFF; rb2 = 6;
        #1;
        chk("b_oob_bypass", 64'(db2), 64'd0);
        tick();
        we2 = 0; rb2 = 5; ra2 = 4;
        #1;
        chk("b_oob5_read", 64'(db2), 64'd0);
        chk("b_r4_kept", 64'(da2), 64'h44);
        clr2 = 1;
        tick();
        clr2 = 0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (busy2) nbusy++;
            chk("b_cnt_range", 64'(dut_b.cnt <= 3'd4), 64'd1);
            tick();
        end
        chk("b_busy_cycles", 64'(nbusy), 64'd5);
        ra2 = 4; rb2 = 1;
        #1;
        chk("b_swept_r4", 64'(da2), 64'd0);
        chk("b_swept_r1", 64'(db2), 64'd0);
        we2 = 1; wa2 = 4; wd2 = 8'h9A;
        tick();
        we2 = 0;
        #1;
        chk("b_r4_writable", 64'(da2), 64'h9A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
